// File: rtl/sfp_tx_scheduler_if.sv
// rtl/sfp_tx_scheduler_if.sv - frame-source request/ack and SFP TX handshake bundle
interface sfp_tx_scheduler_if #(
  parameter int C_DATA_FRAME_BIT = 128
);
  logic                        i_pass_req;
  logic [C_DATA_FRAME_BIT-1:0] i_pass_data;
  logic                        i_zynq_req;
  logic [C_DATA_FRAME_BIT-1:0] i_zynq_data;
  logic                        i_dsp_req;
  logic [C_DATA_FRAME_BIT-1:0] i_dsp_data;
  logic                        i_stat_en;
  logic [C_DATA_FRAME_BIT-1:0] i_stat_data;
  logic                        o_pass_ack;
  logic                        o_zynq_ack;
  logic                        o_dsp_ack;
  logic [C_DATA_FRAME_BIT-1:0] o_tx_data;
  logic                        o_tx_start;
  logic                        i_tx_done;
  logic [1:0]                  o_grant_id;
  logic                        o_busy;
  logic                        o_timeout;
  logic                        i_clr_timeout;

  modport master (
    output i_pass_req, i_pass_data, i_zynq_req, i_zynq_data, i_dsp_req, i_dsp_data,
           i_stat_en, i_stat_data, i_tx_done, i_clr_timeout,
    input  o_pass_ack, o_zynq_ack, o_dsp_ack, o_tx_data, o_tx_start, o_grant_id,
           o_busy, o_timeout
  );

  modport slave (
    input  i_pass_req, i_pass_data, i_zynq_req, i_zynq_data, i_dsp_req, i_dsp_data,
           i_stat_en, i_stat_data, i_tx_done, i_clr_timeout,
    output o_pass_ack, o_zynq_ack, o_dsp_ack, o_tx_data, o_tx_start, o_grant_id,
           o_busy, o_timeout
  );
endinterface

// File: rtl/sfp_tx_scheduler.sv
// rtl/sfp_tx_scheduler.sv - arbitrates four frame sources onto the single SFP transmitter
module sfp_tx_scheduler #(
  parameter int C_DATA_FRAME_BIT = 128,
  parameter int C_STAT_PERIOD    = 200,
  parameter int C_TX_TIMEOUT     = 4095
) (
  input  logic              i_clk,
  input  logic              i_rst,
  sfp_tx_scheduler_if.slave bus
);
  localparam int SW = $clog2(C_STAT_PERIOD);
  localparam int TW = $clog2(C_TX_TIMEOUT + 1);

  localparam logic [1:0] ID_PASS = 2'd0;
  localparam logic [1:0] ID_ZYNQ = 2'd1;
  localparam logic [1:0] ID_DSP  = 2'd2;
  localparam logic [1:0] ID_STAT = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_START, S_WAIT, S_GAP} state_t;

  state_t                      state, state_nxt;
  logic [1:0]                  rr_ptr;
  logic [1:0]                  cand0, cand1, cand2;
  logic [1:0]                  win_id;
  logic                        win_valid;
  logic [C_DATA_FRAME_BIT-1:0] win_data;
  logic                        grant;
  logic                        set_timeout;
  logic                        stat_pending;
  logic                        stat_wrap;
  logic                        stat_clr;
  logic [SW-1:0]               stat_cnt;
  logic [TW-1:0]               wait_cnt;
  logic [TW-1:0]               wait_cnt_inc;

  function automatic logic [1:0] rr_next(input logic [1:0] id);
    case (id)
      ID_ZYNQ: return ID_DSP;
      ID_DSP:  return ID_STAT;
      default: return ID_ZYNQ;
    endcase
  endfunction

  function automatic logic rr_req(input logic [1:0] id, input logic z, input logic d,
                                  input logic s);
    case (id)
      ID_ZYNQ: return z;
      ID_DSP:  return d;
      ID_STAT: return s;
      default: return 1'b0;
    endcase
  endfunction

  // Pass-through always wins; the rest are scanned starting at the round-robin pointer.
  always_comb begin
    cand0     = rr_ptr;
    cand1     = rr_next(cand0);
    cand2     = rr_next(cand1);
    win_valid = 1'b1;
    win_id    = ID_PASS;
    if (bus.i_pass_req)
      win_id = ID_PASS;
    else if (rr_req(cand0, bus.i_zynq_req, bus.i_dsp_req, stat_pending))
      win_id = cand0;
    else if (rr_req(cand1, bus.i_zynq_req, bus.i_dsp_req, stat_pending))
      win_id = cand1;
    else if (rr_req(cand2, bus.i_zynq_req, bus.i_dsp_req, stat_pending))
      win_id = cand2;
    else
      win_valid = 1'b0;
  end

  always_comb begin
    case (win_id)
      ID_PASS: win_data = bus.i_pass_data;
      ID_ZYNQ: win_data = bus.i_zynq_data;
      ID_DSP:  win_data = bus.i_dsp_data;
      default: win_data = bus.i_stat_data;
    endcase
  end

  assign wait_cnt_inc = wait_cnt + TW'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    grant          = 1'b0;
    set_timeout    = 1'b0;
    bus.o_pass_ack = 1'b0;
    bus.o_zynq_ack = 1'b0;
    bus.o_dsp_ack  = 1'b0;
    bus.o_tx_start = 1'b0;
    bus.o_busy     = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (win_valid) begin
          grant     = 1'b1;
          state_nxt = S_LATCH;
        end
      end
      S_LATCH: begin
        bus.o_pass_ack = (bus.o_grant_id == ID_PASS);
        bus.o_zynq_ack = (bus.o_grant_id == ID_ZYNQ);
        bus.o_dsp_ack  = (bus.o_grant_id == ID_DSP);
        state_nxt      = S_START;
      end
      S_START: begin
        bus.o_tx_start = 1'b1;
        state_nxt      = S_WAIT;
      end
      S_WAIT: begin
        // Done on the final cycle takes precedence over the timeout.
        if (bus.i_tx_done) begin
          state_nxt = S_GAP;
        end else if (wait_cnt_inc == TW'(C_TX_TIMEOUT)) begin
          set_timeout = 1'b1;
          state_nxt   = S_GAP;
        end
      end
      S_GAP:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bus.o_tx_data  <= '0;
      bus.o_grant_id <= ID_PASS;
      bus.o_timeout  <= 1'b0;
      rr_ptr         <= ID_ZYNQ;
      wait_cnt       <= '0;
    end else begin
      if (grant) begin
        bus.o_tx_data  <= win_data;
        bus.o_grant_id <= win_id;
        if (win_id != ID_PASS)
          rr_ptr <= rr_next(win_id);
      end
      if (state == S_START)
        wait_cnt <= '0;
      else if (state == S_WAIT)
        wait_cnt <= wait_cnt_inc;
      if (set_timeout)
        bus.o_timeout <= 1'b1;
      else if (bus.i_clr_timeout)
        bus.o_timeout <= 1'b0;
    end
  end

  assign stat_wrap = (stat_cnt == SW'(C_STAT_PERIOD - 1));
  assign stat_clr  = (state == S_LATCH) && (bus.o_grant_id == ID_STAT);

  // A single pending flag: wraps that arrive while a status frame is still queued are absorbed.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stat_cnt     <= '0;
      stat_pending <= 1'b0;
    end else begin
      stat_cnt <= stat_wrap ? '0 : stat_cnt + SW'(1);
      if (!bus.i_stat_en)
        stat_pending <= 1'b0;
      else if (stat_wrap)
        stat_pending <= 1'b1;
      else if (stat_clr)
        stat_pending <= 1'b0;
    end
  end
endmodule

// File: doc/sfp_tx_scheduler.md
# sfp_tx_scheduler

Shares the single SFP frame transmitter among four frame sources: ring pass-through, Zynq command, DSP PI-parameter and periodic slave status. The block sits between the AXI-Lite register/frame-assembly logic and the SFP TX core. It arbitrates requests and latches the winning 128-bit frame. It then issues a one-cycle start pulse, waits for transmit completion (with timeout) and acknowledges the requester.

## Interface
- C_DATA_FRAME_BIT, 128, frame width (cmd[127:112], slv_id[111:96], data_1..3)
- C_STAT_PERIOD, 200, clock cycles between status-frame requests (≥2)
- C_TX_TIMEOUT, 4095, max WAIT cycles for i_tx_done (≥1, counter width $clog2(C_TX_TIMEOUT+1))

- i_clk  in  1  system clock
- i_rst  in  1  asynchronous, active-high reset
- i_pass_req  in  1  pass-through frame pending (level, held until ack)
- i_pass_data  in  C_DATA_FRAME_BIT  pass-through frame
- i_zynq_req  in  1  Zynq command pending (level)
- i_zynq_data  in  C_DATA_FRAME_BIT  Zynq command frame
- i_dsp_req  in  1  DSP PI-parameter frame pending (level)
- i_dsp_data  in  C_DATA_FRAME_BIT  DSP frame
- i_stat_en  in  1  enables periodic status frames (slave mode)
- i_stat_data  in  C_DATA_FRAME_BIT  status frame, sampled at grant
- o_pass_ack, o_zynq_ack, o_dsp_ack  out  1 each  one-cycle grant acknowledge
- o_tx_data  out  C_DATA_FRAME_BIT  latched frame to SFP TX
- o_tx_start  out  1  one-cycle start pulse
- i_tx_done  in  1  TX completion pulse (ignored outside WAIT)
- o_grant_id  out  2  last granted source: 0 pass, 1 zynq, 2 dsp, 3 status
- o_busy  out  1  high in any state other than IDLE
- o_timeout  out  1  sticky timeout flag
- i_clr_timeout  in  1  clears o_timeout (set wins if simultaneous)

## Operation
- FSM: IDLE → LATCH → START → WAIT → GAP → IDLE.
- IDLE: if any request is valid, select a winner. On the same edge, register o_tx_data, o_grant_id and grant, then go to LATCH.
- Arbitration: pass-through has absolute priority, because the ring must not stall. Zynq, DSP and status are round-robin. The pointer starts at zynq after reset and moves to the source after the one granted. Pass-through grants do not move the pointer.
- LATCH: ack for the granted source is high for this one cycle. For a status grant, stat_pending clears. → START.
- START: o_tx_start is high for one cycle. The timeout counter clears. → WAIT.
- WAIT: the counter increments each cycle.
  - i_tx_done → GAP.
  - Otherwise, counter == C_TX_TIMEOUT → set o_timeout, → GAP.
  - i_tx_done in the same cycle as the timeout counts as done; o_timeout is not set.
- GAP: one idle cycle that guarantees inter-frame spacing. → IDLE.
- Status timer: free-running counter 0..C_STAT_PERIOD-1 that wraps to 0. At the wrap, stat_pending is set if i_stat_en=1. When the set coincides with a LATCH clear, set wins. A wrap while stat_pending is already set is absorbed, so at most one status frame is pending. i_stat_en=0 clears stat_pending.
- A request dropped before ack is simply not served. The frame is sampled only at the IDLE→LATCH edge.

## Timing
- Reset values: all outputs 0, FSM IDLE, RR pointer = zynq, stat_pending 0, status and timeout counters 0. Reset asserted mid-frame aborts immediately. No ack or start is issued after reset release until a new request arrives.
- Latency:
  - Request high with FSM in IDLE at edge k: ack is high in cycle k+1 and o_tx_start is high in cycle k+2.
  - o_tx_data is stable from cycle k+1 until the next grant.
- Minimum frame period: 5 cycles, with i_tx_done arriving in the first WAIT cycle.
- Requesters must drop req on the cycle after ack, otherwise the same frame is resent.

## Test plan
- Single Zynq request, frame 0x0001_0000_…_0001, i_tx_done 10 cycles after start → ack at k+1, start at k+2, o_tx_data equals the frame, o_grant_id=1, o_busy low after GAP.
- Zynq, DSP and pass requests all raised in the same cycle, held until ack → grant order pass, zynq, dsp. The pointer is unchanged by the pass grant.
- Zynq and DSP held continuously for 6 frames with i_stat_en=0 → alternating grants 1,2,1,2,1,2.
- i_stat_en=1, C_STAT_PERIOD=200, no other requests → a status start every ≥200 cycles. Two wraps during a long WAIT produce only one pending frame.
- i_tx_done withheld, C_TX_TIMEOUT=15 → o_timeout set exactly 15 WAIT cycles after start, FSM returns to IDLE. i_clr_timeout clears it. Done in the same cycle as the timeout leaves the flag clear.
- i_rst pulsed during WAIT → all outputs 0 on the same cycle. A request after release is served from zynq pointer state.
